store_rmw_unit: RTL

Store-path companion to the load-side sign/zero-extend stage: accepts SB/SH/SW requests from the non-pipelined core and writes them into a data memory that has no byte enables. SW is written directly. SB/SH are done as a read-modify-write: read the word, merge the byte or halfword into its lane, write the word back. Misaligned stores are rejected without touching memory. Sits between the core's memory-stage control and the data-memory port.

---
 rtl/store_rmw_unit_if.sv | 53 +++++
 rtl/store_rmw_unit.sv | 99 +++++++++
 2 files changed

// File: rtl/store_rmw_unit_if.sv
`default_nettype none
// ============================================================================
// store_rmw_unit_if : memory-op encoding plus the request/response and
//                     data-memory bus shared by the store RMW unit.
// Revision 1.0
// ============================================================================

package controls;
   typedef enum logic [3:0] {
      MEM_NONE = 4'd0,
      MEM_LB   = 4'd1,
      MEM_LH   = 4'd2,
      MEM_LW   = 4'd3,
      MEM_LBU  = 4'd4,
      MEM_LHU  = 4'd5,
      MEM_SB   = 4'd6,
      MEM_SH   = 4'd7,
      MEM_SW   = 4'd8
   } mem_op;
endpackage

interface store_rmw_unit_if #(
   parameter int WORD_SIZE = 32,
   parameter int ADDR_SIZE = 32
);
   import controls::*;

   logic                 req_valid;
   logic                 req_ready;
   mem_op                op;
   logic [ADDR_SIZE-1:0] addr;
   logic [WORD_SIZE-1:0] wdata;
   logic                 done;
   logic                 misaligned;
   logic [ADDR_SIZE-1:0] mem_addr;
   logic                 mem_re;
   logic [WORD_SIZE-1:0] mem_rdata;
   logic                 mem_we;
   logic [WORD_SIZE-1:0] mem_wdata;

   // Core and data memory together form the master side.
   modport master (
      output req_valid, op, addr, wdata, mem_rdata,
      input  req_ready, done, misaligned, mem_addr, mem_re, mem_we, mem_wdata
   );

   modport slave (
      input  req_valid, op, addr, wdata, mem_rdata,
      output req_ready, done, misaligned, mem_addr, mem_re, mem_we, mem_wdata
   );
endinterface

`default_nettype wire

// File: rtl/store_rmw_unit.sv
`default_nettype none
// ============================================================================
// store_rmw_unit : SB/SH/SW store engine for a data memory without byte
//                  enables; sub-word stores become read-modify-write.
// Revision 1.0
// ============================================================================

module store_rmw_unit #(
   parameter int WORD_SIZE = 32,
   parameter int ADDR_SIZE = 32
) (
   input  wire logic           clk,
   input  wire logic           reset,
   store_rmw_unit_if.slave     bus
);
   import controls::*;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RD    = 3'd1;
   localparam logic [2:0] S_MERGE = 3'd2;
   localparam logic [2:0] S_WR    = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;

   logic [2:0]           r_state;
   mem_op                r_op;
   logic [1:0]           r_lane;
   logic                 r_mis;
   logic [ADDR_SIZE-1:0] r_mem_addr;
   logic [WORD_SIZE-1:0] r_word;

   logic                 w_is_store;
   logic                 w_mis;
   logic [WORD_SIZE-1:0] w_merged;

   assign w_is_store = (bus.op == MEM_SB) || (bus.op == MEM_SH) || (bus.op == MEM_SW);
   assign w_mis      = ((bus.op == MEM_SH) && bus.addr[0]) ||
                       ((bus.op == MEM_SW) && (bus.addr[1:0] != 2'b00));

   // r_word still holds the store data here; only its low lane(s) are used.
   always_comb begin
      w_merged = bus.mem_rdata;
      if (r_op == MEM_SB) begin
         case (r_lane)
            2'd0:    w_merged[7:0]   = r_word[7:0];
            2'd1:    w_merged[15:8]  = r_word[7:0];
            2'd2:    w_merged[23:16] = r_word[7:0];
            default: w_merged[31:24] = r_word[7:0];
         endcase
      end else if (r_op == MEM_SH) begin
         if (r_lane[1]) w_merged[31:16] = r_word[15:0];
         else           w_merged[15:0]  = r_word[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_op       <= MEM_NONE;
         r_lane     <= 2'd0;
         r_mis      <= 1'b0;
         r_mem_addr <= '0;
         r_word     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_op       <= bus.op;
                  r_lane     <= bus.addr[1:0];
                  r_mis      <= w_mis;
                  r_mem_addr <= {bus.addr[ADDR_SIZE-1:2], 2'b00};
                  r_word     <= bus.wdata;
                  if (w_mis || !w_is_store) r_state <= S_RESP;
                  else if (bus.op == MEM_SW) r_state <= S_WR;
                  else                       r_state <= S_RD;
               end
            end
            S_RD:    r_state <= S_MERGE;
            S_MERGE: begin
               r_word  <= w_merged;
               r_state <= S_WR;
            end
            S_WR:    r_state <= S_IDLE;
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready  = (r_state == S_IDLE) && !reset;
   assign bus.done       = (r_state == S_WR) || (r_state == S_RESP);
   assign bus.misaligned = (r_state == S_RESP) && r_mis;
   assign bus.mem_re     = (r_state == S_RD);
   assign bus.mem_we     = (r_state == S_WR);
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_wdata  = r_word;

endmodule

`default_nettype wire
